// File: rtl/ps2_hack_keyboard.sv
// PS/2 scan-code set 2 receiver and decoder producing the Hack KBD key code.
// Output holds the most recently pressed mapped key until that key is released.
module ps2_hack_keyboard #(
  parameter int FILTER_LEN    = 8,
  parameter int FRAME_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] hack_scancode,
  output logic       frame_err
);
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_e;

  logic [1:0]     clk_sync_q, data_sync_q;
  logic           clk_f_q;
  logic [FCW-1:0] flt_cnt_q;
  logic           clk_s, data_s, flt_flip, strobe;

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign flt_flip = (clk_s != clk_f_q) && (flt_cnt_q == FCW'(FILTER_LEN - 1));
  assign strobe   = flt_flip && clk_f_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_f_q     <= 1'b1;
      flt_cnt_q   <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      if (clk_s == clk_f_q) begin
        flt_cnt_q <= '0;
      end else if (flt_flip) begin
        clk_f_q   <= clk_s;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FCW'(1);
      end
    end
  end

  // Receiver. byte_valid_q pulses for one cycle after a good stop bit; shift_q
  // holds the received byte and stays stable until the next start bit.
  rx_state_e      rx_state_q, rx_state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           byte_valid_q, byte_valid_d;
  logic           frame_err_q, frame_err_d;

  always_comb begin
    rx_state_d   = rx_state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    to_cnt_d     = '0;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      S_IDLE: if (strobe && !data_s) begin
        rx_state_d = S_DATA;
        bit_cnt_d  = 3'd0;
      end
      S_DATA: if (strobe) begin
        shift_d   = {data_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) rx_state_d = S_PARITY;
      end
      S_PARITY: if (strobe) begin
        if (^{shift_q, data_s}) rx_state_d = S_STOP;
        else begin
          rx_state_d  = S_IDLE;
          frame_err_d = 1'b1;
        end
      end
      S_STOP: if (strobe) begin
        rx_state_d = S_IDLE;
        if (data_s) byte_valid_d = 1'b1;
        else        frame_err_d  = 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
    if (rx_state_q != S_IDLE && !strobe) begin
      if (to_cnt_q == TCW'(FRAME_TIMEOUT - 1)) begin
        rx_state_d  = S_IDLE;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state_q   <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Returns 0 for unmapped keys.
  function automatic logic [7:0] map_key(input logic ext, input logic [7:0] b, input logic sh);
    logic [15:0] p;
    p = 16'h0;
    if (ext) begin
      case (b)
        8'h6B: p = {8'd130, 8'd130};  8'h75: p = {8'd131, 8'd131};
        8'h74: p = {8'd132, 8'd132};  8'h72: p = {8'd133, 8'd133};
        8'h6C: p = {8'd134, 8'd134};  8'h69: p = {8'd135, 8'd135};
        8'h7D: p = {8'd136, 8'd136};  8'h7A: p = {8'd137, 8'd137};
        8'h70: p = {8'd138, 8'd138};  8'h71: p = {8'd139, 8'd139};
        8'h5A: p = {8'd128, 8'd128};
        default: p = 16'h0;
      endcase
    end else begin
      case (b)
        8'h1C: p = {8'd97,  8'd65};  8'h32: p = {8'd98,  8'd66};  8'h21: p = {8'd99,  8'd67};
        8'h23: p = {8'd100, 8'd68};  8'h24: p = {8'd101, 8'd69};  8'h2B: p = {8'd102, 8'd70};
        8'h34: p = {8'd103, 8'd71};  8'h33: p = {8'd104, 8'd72};  8'h43: p = {8'd105, 8'd73};
        8'h3B: p = {8'd106, 8'd74};  8'h42: p = {8'd107, 8'd75};  8'h4B: p = {8'd108, 8'd76};
        8'h3A: p = {8'd109, 8'd77};  8'h31: p = {8'd110, 8'd78};  8'h44: p = {8'd111, 8'd79};
        8'h4D: p = {8'd112, 8'd80};  8'h15: p = {8'd113, 8'd81};  8'h2D: p = {8'd114, 8'd82};
        8'h1B: p = {8'd115, 8'd83};  8'h2C: p = {8'd116, 8'd84};  8'h3C: p = {8'd117, 8'd85};
        8'h2A: p = {8'd118, 8'd86};  8'h1D: p = {8'd119, 8'd87};  8'h22: p = {8'd120, 8'd88};
        8'h35: p = {8'd121, 8'd89};  8'h1A: p = {8'd122, 8'd90};
        8'h45: p = {8'd48, 8'd41};   8'h16: p = {8'd49, 8'd33};   8'h1E: p = {8'd50, 8'd64};
        8'h26: p = {8'd51, 8'd35};   8'h25: p = {8'd52, 8'd36};   8'h2E: p = {8'd53, 8'd37};
        8'h36: p = {8'd54, 8'd94};   8'h3D: p = {8'd55, 8'd38};   8'h3E: p = {8'd56, 8'd42};
        8'h46: p = {8'd57, 8'd40};
        8'h0E: p = {8'd96, 8'd126};  8'h4E: p = {8'd45, 8'd95};   8'h55: p = {8'd61, 8'd43};
        8'h54: p = {8'd91, 8'd123};  8'h5B: p = {8'd93, 8'd125};  8'h5D: p = {8'd92, 8'd124};
        8'h4C: p = {8'd59, 8'd58};   8'h52: p = {8'd39, 8'd34};   8'h41: p = {8'd44, 8'd60};
        8'h49: p = {8'd46, 8'd62};   8'h4A: p = {8'd47, 8'd63};
        8'h29: p = {8'd32, 8'd32};   8'h5A: p = {8'd128, 8'd128};
        8'h66: p = {8'd129, 8'd129}; 8'h76: p = {8'd140, 8'd140};
        8'h05: p = {8'd141, 8'd141}; 8'h06: p = {8'd142, 8'd142}; 8'h04: p = {8'd143, 8'd143};
        8'h0C: p = {8'd144, 8'd144}; 8'h03: p = {8'd145, 8'd145}; 8'h0B: p = {8'd146, 8'd146};
        8'h83: p = {8'd147, 8'd147}; 8'h0A: p = {8'd148, 8'd148}; 8'h01: p = {8'd149, 8'd149};
        8'h09: p = {8'd150, 8'd150}; 8'h78: p = {8'd151, 8'd151}; 8'h07: p = {8'd152, 8'd152};
        default: p = 16'h0;
      endcase
    end
    return sh ? p[7:0] : p[15:8];
  endfunction

  logic       ext_q, ext_d, brk_q, brk_d, shl_q, shl_d, shr_q, shr_d;
  logic [8:0] last_key_q, last_key_d;
  logic [2:0] skip_q, skip_d;
  logic [7:0] code_q, code_d, mapped;
  logic       noise;

  assign mapped = map_key(ext_q, shift_q, shl_q | shr_q);
  assign noise  = (shift_q == 8'hAA) || (shift_q == 8'hFA) || (shift_q == 8'hEE) ||
                  (shift_q == 8'hFE) || (shift_q == 8'h00) || (shift_q == 8'hFF);

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    shl_d      = shl_q;
    shr_d      = shr_q;
    last_key_d = last_key_q;
    skip_d     = skip_q;
    code_d     = code_q;
    if (byte_valid_q) begin
      if (skip_q != 3'd0)          skip_d = skip_q - 3'd1;
      else if (shift_q == 8'hE1)   skip_d = 3'd7;
      else if (shift_q == 8'hE0)   ext_d  = 1'b1;
      else if (shift_q == 8'hF0)   brk_d  = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ext_q && !brk_q && noise) begin
          code_d = code_q;
        end else if (!ext_q && shift_q == 8'h12) begin
          shl_d = !brk_q;
        end else if (!ext_q && shift_q == 8'h59) begin
          shr_d = !brk_q;
        end else if (brk_q) begin
          if ({ext_q, shift_q} == last_key_q) code_d = 8'd0;
        end else if (mapped != 8'd0) begin
          code_d     = mapped;
          last_key_d = {ext_q, shift_q};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      shl_q      <= 1'b0;
      shr_q      <= 1'b0;
      last_key_q <= '0;
      skip_q     <= '0;
      code_q     <= '0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      shl_q      <= shl_d;
      shr_q      <= shr_d;
      last_key_q <= last_key_d;
      skip_q     <= skip_d;
      code_q     <= code_d;
    end
  end

  assign hack_scancode = code_q;
  assign frame_err     = frame_err_q;
endmodule

// File: doc/ps2_hack_keyboard.md
Name: ps2_hack_keyboard

Overview:
Upstream keyboard stage for the Hack memory map. Receives raw PS/2 clock and data lines and decodes scan-code set 2 frames. Translates make and break sequences into the Hack keyboard code and drives `hack_scancode`, which the memory block exposes at the KBD register. Output holds the code of the most recently pressed key and reads 0 when no tracked key is held.

Parameters:
FILTER_LEN, 8, number of consecutive identical samples of the synced ps2_clk needed to change the filtered level.
FRAME_TIMEOUT, 100000, clk cycles allowed between filtered ps2_clk falling edges inside a frame before it is aborted.

Ports:
clk  input  1  system clock; the same clock as the CPU and memory.
reset  input  1  synchronous, active-low reset (asserted when 0).
ps2_clk  input  1  raw PS/2 clock, asynchronous.
ps2_data  input  1  raw PS/2 data, asynchronous.
hack_scancode  output  8  Hack key code of the held key; 0 = none.
frame_err  output  1  one-cycle pulse on a rejected frame.

Behaviour:
- **Reset** (reset==0 at a clk edge):
  - hack_scancode=0, frame_err=0.
  - Receiver returns to IDLE.
  - ext, brk, shift_l, shift_r, last_key and the E1 skip counter are all cleared.
  - A partial frame in progress is discarded.
- **Input conditioning:**
  - Both lines pass through a 2-flop synchronizer.
  - Filtered ps2_clk changes only after FILTER_LEN equal consecutive samples.
  - A falling edge of the filtered clock is the sample strobe; data is taken from the synced ps2_data.
- **Receiver FSM:** IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: on a strobe, data=0 goes to DATA; data=1 stays in IDLE with no error.
  - DATA: shifts 8 bits LSB-first.
  - PARITY: requires odd parity over the data plus parity bit.
  - STOP: requires 1.
  - Parity or stop failure: byte dropped, frame_err high for exactly 1 cycle, back to IDLE.
  - Timeout: in any non-IDLE state, FRAME_TIMEOUT cycles without a strobe → IDLE plus a frame_err pulse. The timeout counter clears on every strobe.
  - A good stop bit produces byte_valid, an internal one-cycle pulse, on the cycle after the stop strobe.
- **Decoder** (acts on byte_valid):
  - E1 byte: the next 7 bytes are dropped (pause sequence); no state change.
  - E0 byte: ext=1.
  - F0 byte: brk=1.
  - Any other byte: forms key={ext,byte}, processed as below, then ext=brk=0.
  - Bytes AA, FA, EE, FE, 00, FF with ext=0 and brk=0 are ignored.
  - Make of shift (non-ext 12 or 59): sets shift_l or shift_r; hack_scancode unchanged.
  - Break of shift: clears shift_l or shift_r; hack_scancode unchanged.
  - Make of a mapped key: hack_scancode ← code; last_key ← key. The code is translated with shift = shift_l|shift_r at make time.
  - Typematic repeat rewrites the same value.
  - Make of an unmapped key: ignored.
  - Break with key==last_key: hack_scancode ← 0.
  - Break with any other key: no change.
  - Changing shift while a key is held does not retranslate the held code.
- **Latency:** hack_scancode updates exactly 2 cycles after the stop-bit strobe.
- **Map, non-ext keys:**
  - Letters → 'a'–'z' (97–122) unshifted, 'A'–'Z' (65–90) shifted.
  - Top-row digits → '0'–'9', shifted ")!@#$%^&*(".
  - Punctuation, unshifted/shifted: `` ` ``/~, -/_, =/+, [/{, ]/}, \\/|, ;/:, '/", ,/<, ./>, / /?.
  - 29 → 32 (space).
  - 5A → 128 (newline), 66 → 129 (backspace), 76 → 140 (esc).
  - F1–F12 → 141–152 (F1=05, F2=06, F3=04, F4=0C, F5=03, F6=0B, F7=83, F8=0A, F9=01, F10=09, F11=78, F12=07).
- **Map, ext keys:**
  - 6B → 130 (left), 75 → 131 (up), 74 → 132 (right), 72 → 133 (down).
  - 6C → 134 (home), 69 → 135 (end), 7D → 136 (page up), 7A → 137 (page down).
  - 70 → 138 (insert), 71 → 139 (delete), 5A → 128 (keypad enter).
- **Unmapped keys:** all others, including keypad, ctrl, alt, caps lock and tab.

Test Plan:
1. Frame 1C → hack_scancode=0x61 two cycles after its stop strobe; frames F0,1C → 0x00.
2. Frames 12, 1C → 0x41; F0 1C → 0; F0 12, then 16 → 0x31; frames 12, 16 → 0x21.
3. Frames E0, 75 → 131; E0, F0, 75 → 0; non-ext 75 → remains 0.
4. Frames 1C, 32 → 0x62; F0 1C → stays 0x62; F0 32 → 0.
5. Frame 1C with even parity → frame_err pulses exactly 1 cycle and hack_scancode stays 0. Separately, a frame of 4 bits followed by a stall of FRAME_TIMEOUT+1 cycles → frame_err pulse, after which frame 5A → 128.
6. Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C → output 0 throughout the pause sequence, then 0x61. Separately, reset=0 mid-frame and a fresh frame 66 → 129.
